// File: rtl/move_scheduler.sv
// rtl/move_scheduler.sv - frame-level update sequencer for mover instances; define MOVE_SCHED_ROTATE_EN to rotate the service start object
module move_scheduler #(
  parameter int NUM_OBJ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       startOfFrame,
  input  logic                       pause,
  input  logic                       clear_err,
  input  logic [NUM_OBJ-1:0]         obj_enable,
  input  logic [NUM_OBJ-1:0]         upd_done,
  output logic [NUM_OBJ-1:0]         upd_req,
  output logic [$clog2(NUM_OBJ)-1:0] cur_obj,
  output logic                       frame_busy,
  output logic                       frame_done,
  output logic [15:0]                frame_count,
  output logic                       overrun,
  output logic [NUM_OBJ-1:0]         timeout_err
);

  localparam int IW = $clog2(NUM_OBJ);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_OBJ - 1);
  localparam logic [IW:0]   SCAN_ALL = (IW+1)'(NUM_OBJ);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_SOF_ST,
    SCAN_ST,
    REQ_ST,
    DONE_ST
  } state_t;

  state_t             state;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      start_idx;
  logic [IW:0]        scanned;
  logic [TW-1:0]      tcnt;

  logic [IW-1:0]      idx_inc;
  logic [IW:0]        scanned_inc;
  logic [NUM_OBJ-1:0] idx_onehot;
  logic               req_done;
  logic               req_tmo;

  // cur_obj is the registered scan/service index itself
  assign cur_obj = idx;

  // next-index arithmetic and request completion conditions
  always_comb begin
    idx_inc          = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    scanned_inc      = scanned + 1'b1;
    idx_onehot       = '0;
    idx_onehot[idx]  = 1'b1;
    req_done         = (state == REQ_ST) && upd_done[idx];
    // a done in the final allowed cycle wins over the timeout
    req_tmo          = (state == REQ_ST) && !upd_done[idx] && (tcnt == T_LAST);
  end

`ifdef MOVE_SCHED_ROTATE_EN
  logic [IW-1:0] start_inc;
  assign start_inc = (start_idx == LAST_IDX) ? '0 : start_idx + 1'b1;
`endif

  // frame sequencing FSM with registered request, busy, done and count outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= WAIT_SOF_ST;
      idx         <= '0;
      start_idx   <= '0;
      scanned     <= '0;
      tcnt        <= '0;
      upd_req     <= '0;
      frame_busy  <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        WAIT_SOF_ST: begin
          // paused frames are skipped entirely: no count, no rotation
          if (startOfFrame && !pause) begin
            state      <= SCAN_ST;
            idx        <= start_idx;
            scanned    <= '0;
            frame_busy <= 1'b1;
          end
        end

        SCAN_ST: begin
          if (scanned == SCAN_ALL) begin
            state      <= DONE_ST;
            frame_done <= 1'b1;
          end else if (obj_enable[idx]) begin
            state   <= REQ_ST;
            upd_req <= idx_onehot;
            tcnt    <= '0;
          end else begin
            idx     <= idx_inc;
            scanned <= scanned_inc;
            // skipping the last unvisited object finishes the frame directly
            if (scanned_inc == SCAN_ALL) begin
              state      <= DONE_ST;
              frame_done <= 1'b1;
            end
          end
        end

        REQ_ST: begin
          if (req_done || req_tmo) begin
            upd_req <= '0;
            state   <= SCAN_ST;
            idx     <= idx_inc;
            scanned <= scanned_inc;
            tcnt    <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        DONE_ST: begin
          frame_count <= frame_count + 16'd1;
          frame_busy  <= 1'b0;
          state       <= WAIT_SOF_ST;
`ifdef MOVE_SCHED_ROTATE_EN
          start_idx   <= start_inc;
`else
          start_idx   <= '0;
`endif
        end

        default: begin
          state   <= WAIT_SOF_ST;
          upd_req <= '0;
        end
      endcase
    end
  end

  // sticky error flags; a new set condition overrides a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun     <= 1'b0;
      timeout_err <= '0;
    end else begin
      overrun     <= (overrun && !clear_err) || (startOfFrame && frame_busy);
      timeout_err <= (clear_err ? '0 : timeout_err) | (req_tmo ? idx_onehot : '0);
    end
  end

endmodule

// File: tb/tb_move_scheduler.sv
// tb/tb_move_scheduler.sv - self-checking bench for move_scheduler
module tb_move_scheduler;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       pause = 1'b0;
  logic       clear_err = 1'b0;
  logic [3:0] obj_enable = 4'b0000;
  logic [3:0] upd_done = 4'b0000;
  logic [3:0] upd_req;
  logic [1:0] cur_obj;
  logic       frame_busy;
  logic       frame_done;
  logic [15:0] frame_count;
  logic       overrun;
  logic [3:0] timeout_err;

  move_scheduler #(.NUM_OBJ(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .pause(pause),
    .clear_err(clear_err), .obj_enable(obj_enable), .upd_done(upd_done),
    .upd_req(upd_req), .cur_obj(cur_obj), .frame_busy(frame_busy),
    .frame_done(frame_done), .frame_count(frame_count), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int obj;
    int dur;
  } exp_t;

  typedef struct {
    string      name;
    logic [3:0] en;
    int         d0, d1, d2, d3;   // done delay after request rise, -1 = never
    bit         noise;            // drive done on a non-requested index too
    bit         pse;
    logic [3:0] exp_terr;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   dly[4] = '{0, 0, 0, 0};
  bit   noise_en = 1'b0;
  int   act_obj = -1;
  int   act_len = 0;
  int   act_dur = 0;
  int   first_rise_cyc = -1;
  int   first_obj = -1;
  int   fd_pulses = 0;
  int   mon_o;
  int   exp_count = 0;
  int   exp_start = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // mover model and request monitor, evaluated away from the active edge
  always @(negedge clk) begin
    if (reset) begin
      act_obj  = -1;
      upd_done = 4'b0000;
    end else begin
      if (frame_done) fd_pulses++;
      if (act_obj >= 0 && !upd_req[act_obj]) begin
        check("req_duration", act_len, act_dur);
        act_obj = -1;
      end
      if (act_obj < 0 && upd_req != 4'b0000) begin
        check("req_onehot", $countones(upd_req), 1);
        mon_o = 0;
        for (int i = 0; i < 4; i++) if (upd_req[i]) mon_o = i;
        if (sb.size() == 0) begin
          check("req_unexpected", mon_o + 1, 0);
          act_dur = 0;
        end else begin
          check("req_obj", mon_o, sb[0].obj);
          act_dur = sb[0].dur;
          void'(sb.pop_front());
        end
        check("cur_obj_in_req", cur_obj, mon_o);
        if (first_rise_cyc < 0) begin
          first_rise_cyc = cyc;
          first_obj      = mon_o;
        end
        act_obj = mon_o;
        act_len = 0;
      end
      if (act_obj >= 0) act_len++;
      upd_done = 4'b0000;
      if (act_obj >= 0) begin
        if (noise_en) upd_done[(act_obj + 1) % 4] = 1'b1;
        if (dly[act_obj] >= 0 && act_len == dly[act_obj] + 1) upd_done[act_obj] = 1'b1;
      end
    end
  end

  task automatic wait_frame_done(output bit seen, output int at);
    seen = 1'b0;
    at   = -1;
    for (int n = 0; n < 400 && !seen; n++) begin
      if (frame_done) begin
        seen = 1'b1;
        at   = cyc;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic advance_model();
    exp_count++;
`ifdef MOVE_SCHED_ROTATE_EN
    exp_start = (exp_start + 1) % 4;
`endif
  endtask

  task automatic run_frame(input vec_t v);
    int  dl[4];
    int  pos, first_lat, done_lat, o, dur, sof_cyc, done_cyc;
    bit  last_en, seen;
    dl = '{v.d0, v.d1, v.d2, v.d3};
    for (int i = 0; i < 4; i++) dly[i] = dl[i];
    noise_en   = v.noise;
    obj_enable = v.en;
    pause      = v.pse;
    pos = 1;
    first_lat = -1;
    last_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      o = (exp_start + k) % 4;
      if (v.en[o]) begin
        dur = (dl[o] < 0) ? TMO : dl[o] + 1;
        if (first_lat < 0) first_lat = pos + 1;
        if (!v.pse) sb.push_back('{o, dur});
        pos = pos + 1 + dur;
        last_en = 1'b1;
      end else begin
        pos = pos + 1;
        last_en = 1'b0;
      end
    end
    done_lat = last_en ? pos + 1 : pos;
    first_rise_cyc = -1;
    fd_pulses = 0;
    @(negedge clk);
    startOfFrame = 1'b1;
    sof_cyc = cyc;
    @(negedge clk);
    startOfFrame = 1'b0;
    if (!v.pse) begin
      wait_frame_done(seen, done_cyc);
      check({v.name, "/frame_done_seen"}, seen, 1);
      if (seen) begin
        check({v.name, "/done_latency"}, done_cyc - sof_cyc, done_lat);
        if (first_lat >= 0) check({v.name, "/first_req_latency"}, first_rise_cyc - sof_cyc, first_lat);
      end
      @(negedge clk);
      check({v.name, "/frame_done_one_cycle"}, frame_done, 0);
      check({v.name, "/busy_after_done"}, frame_busy, 0);
      advance_model();
    end else begin
      repeat (20) @(negedge clk);
      check({v.name, "/paused_busy"}, frame_busy, 0);
    end
    check({v.name, "/frame_count"}, frame_count, exp_count & 16'hFFFF);
    check({v.name, "/frame_done_pulses"}, fd_pulses, v.pse ? 0 : 1);
    check({v.name, "/timeout_err"}, timeout_err, v.exp_terr);
    check({v.name, "/overrun_quiet"}, overrun, 0);
    check({v.name, "/sb_drained"}, sb.size(), 0);
    pause = 1'b0;
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check({v.name, "/timeout_err_cleared"}, timeout_err, 0);
  endtask

  vec_t vecs[8];
  vec_t vrot;

  initial begin
    logic [3:0] tgt;
    bit  seen;
    int  at;
    int  cnt_before;

    vecs[0] = '{"all_en",          4'b1111,  3,  3,  3,  3, 1'b0, 1'b0, 4'b0000};
    vecs[1] = '{"en_1010",         4'b1010,  3,  3,  3,  3, 1'b0, 1'b0, 4'b0000};
    vecs[2] = '{"timeout_obj2",    4'b1111,  3,  3, -1,  3, 1'b1, 1'b0, 4'b0100};
    vecs[3] = '{"all_disabled",    4'b0000,  3,  3,  3,  3, 1'b0, 1'b0, 4'b0000};
    vecs[4] = '{"paused",          4'b1111,  3,  3,  3,  3, 1'b0, 1'b1, 4'b0000};
    vecs[5] = '{"last_cycle_done", 4'b1111,  2, 15,  1,  0, 1'b0, 1'b0, 4'b0000};
    vecs[6] = '{"single_obj0",     4'b0001,  0,  0,  0,  0, 1'b0, 1'b0, 4'b0000};
    vecs[7] = '{"two_timeouts",    4'b0101, -1,  3, -1,  3, 1'b0, 1'b0, 4'b0101};
    vrot    = '{"rotate",          4'b1111,  0,  0,  0,  0, 1'b0, 1'b0, 4'b0000};

    // reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst/upd_req", upd_req, 0);
    check("rst/cur_obj", cur_obj, 0);
    check("rst/frame_busy", frame_busy, 0);
    check("rst/frame_done", frame_done, 0);
    check("rst/frame_count", frame_count, 0);
    check("rst/overrun", overrun, 0);
    check("rst/timeout_err", timeout_err, 0);

    for (int i = 0; i < 8; i++) run_frame(vecs[i]);

    // stray frame starts while busy: overrun, clear, and set-beats-clear
    obj_enable = 4'b1111;
    noise_en = 1'b0;
    for (int i = 0; i < 4; i++) dly[i] = 3;
    for (int k = 0; k < 4; k++) sb.push_back('{(exp_start + k) % 4, 4});
    tgt = 4'b0001 << ((exp_start + 1) % 4);
    cnt_before = exp_count;
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      if (upd_req == tgt) seen = 1'b1;
      else @(negedge clk);
    end
    check("ovr/second_obj_reached", seen, 1);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    check("ovr/overrun_set", overrun, 1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("ovr/overrun_cleared", overrun, 0);
    startOfFrame = 1'b1;
    clear_err = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    clear_err = 1'b0;
    check("ovr/set_wins_over_clear", overrun, 1);
    wait_frame_done(seen, at);
    check("ovr/frame_done_seen", seen, 1);
    advance_model();
    repeat (30) @(negedge clk);
    check("ovr/frame_count", frame_count, cnt_before + 1);
    check("ovr/no_extra_frame_busy", frame_busy, 0);
    check("ovr/sb_drained", sb.size(), 0);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("ovr/overrun_final_clear", overrun, 0);

    // asynchronous reset in the middle of a request
    for (int i = 0; i < 4; i++) dly[i] = -1;
    sb.push_back('{exp_start, TMO});
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      if (upd_req != 4'b0000) seen = 1'b1;
      else @(negedge clk);
    end
    check("arst/req_seen", seen, 1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst/upd_req_async", upd_req, 0);
    check("arst/busy_async", frame_busy, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    exp_count = 0;
    exp_start = 0;
    check("arst/cur_obj", cur_obj, 0);
    check("arst/frame_count", frame_count, 0);
    run_frame(vecs[0]);

    // start object across consecutive frames from a fresh reset
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_count = 0;
    exp_start = 0;
    for (int f = 0; f < 3; f++) begin
      run_frame(vrot);
`ifdef MOVE_SCHED_ROTATE_EN
      check("rot/first_obj", first_obj, f);
`else
      check("rot/first_obj", first_obj, 0);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/move_scheduler.md
# move_scheduler

Frame-level controller that sequences position updates across several independent mover instances in the VGA game layer. On each `startOfFrame` it grants a one-hot update request to each enabled object in turn, waits for that object's done handshake (or a timeout), then moves to the next. It sits between the VGA frame-timing source and the mover instances. It also reports frame overruns, per-object timeouts and a frame counter to the game-control logic.

## Interface
Parameters:
- `NUM_OBJ`, 4: number of mover instances; 2..16.
- `TIMEOUT_CYCLES`, 1024: maximum cycles one request may stay high before it is abandoned; ≥2.

Ports:
- `clk`  in  1  system clock; the block's only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `startOfFrame`  in  1  one-cycle pulse at the start of each frame.
- `pause`  in  1  level; while high, new frames are skipped.
- `clear_err`  in  1  one-cycle pulse; clears the sticky error flags.
- `obj_enable`  in  NUM_OBJ  per-object enable, sampled in SCAN_ST.
- `upd_done`  in  NUM_OBJ  per-object done pulse from the movers.
- `upd_req`  out  NUM_OBJ  one-hot request; held high until done or timeout.
- `cur_obj`  out  $clog2(NUM_OBJ)  index currently being scanned or serviced.
- `frame_busy`  out  1  high from frame acceptance until DONE_ST is exited.
- `frame_done`  out  1  one-cycle pulse at the end of each serviced frame.
- `frame_count`  out  16  number of frames serviced; wraps 0xFFFF→0.
- `overrun`  out  1  sticky; a `startOfFrame` arrived while `frame_busy` was high.
- `timeout_err`  out  NUM_OBJ  sticky; per-object timeout flag.

## Operation
State machine:
- WAIT_SOF_ST (reset state).
  - On `startOfFrame` with `pause`=0: go to SCAN_ST and latch `idx`=`start_idx`.
  - On `startOfFrame` with `pause`=1: stay in WAIT_SOF_ST; the frame is skipped and `frame_count` does not change.
- SCAN_ST examines one index per cycle.
  - If `obj_enable[idx]` is high: go to REQ_ST.
  - Otherwise: `idx`←(idx+1) mod NUM_OBJ and `scanned`+1.
  - When `scanned`=NUM_OBJ: go to DONE_ST.
- REQ_ST drives `upd_req[idx]`=1 and increments the timeout counter every cycle.
  - `upd_done[idx]`=1: go to SCAN_ST with `idx`+1 and `scanned`+1.
  - Counter reaches TIMEOUT_CYCLES−1 without done: set `timeout_err[idx]`, then advance exactly as for done.
  - `upd_done` bits for indices other than `idx` are ignored.
- DONE_ST lasts one cycle.
  - Pulse `frame_done`.
  - `frame_count`+1.
  - Update `start_idx` (see Configuration).
  - Go to WAIT_SOF_ST.

Rules:
- Each object is visited at most once per frame. `scanned` is a $clog2(NUM_OBJ)+1-bit counter.
- `cur_obj` = `idx` in every state.
- A `startOfFrame` pulse in any state other than WAIT_SOF_ST is dropped, not queued, and sets `overrun`. The current frame completes normally.
- `pause` rising mid-frame has no effect until the next `startOfFrame`.
- `clear_err` clears `overrun` and `timeout_err`. If a set condition occurs in the same cycle as `clear_err`, the set wins.
- Reset mid-frame: `upd_req` drops immediately (asynchronous); the FSM returns to WAIT_SOF_ST.
- Reset values: `upd_req`=0, `cur_obj`=0, `frame_busy`=0, `frame_done`=0, `frame_count`=0, `overrun`=0, `timeout_err`=0, `start_idx`=0, all internal counters 0.

## Timing
- `startOfFrame` at cycle t → SCAN_ST at t+1 → first `upd_req` high at t+2 if `obj_enable[start_idx]`=1.
- Each disabled object skipped adds 1 cycle.
- `upd_done` at cycle d → `upd_req` low at d+1 (SCAN_ST) → next request at d+2 at the earliest.
- A request that times out stays high for exactly TIMEOUT_CYCLES cycles. `timeout_err` is visible the cycle after the request drops.
- `upd_done` in the final timeout cycle counts as done; no error is flagged.
- `frame_busy` rises at t+1 and falls the cycle after DONE_ST. `frame_done` is asserted during DONE_ST.
- Frame with all objects disabled: DONE_ST is reached at t+1+NUM_OBJ.
- All outputs are registered.

## Configuration
- `MOVE_SCHED_ROTATE_EN` defined:
  - In DONE_ST, `start_idx`←(start_idx+1) mod NUM_OBJ.
  - Service order rotates by one object per serviced frame. Skipped frames do not rotate it.
- `MOVE_SCHED_ROTATE_EN` undefined:
  - `start_idx` is fixed at 0; object 0 is always served first.

## Test plan
- Reset, NUM_OBJ=4, all enabled, each mover returns done 3 cycles after its request rises, SOF at t → requests go 0,1,2,3. `upd_req[0]` rises at t+2. `frame_done` pulses once. `frame_count`=1.
- `obj_enable`=4'b1010, SOF → only `upd_req[1]` and `upd_req[3]` are asserted. Cycles spent in SCAN_ST on indices 0 and 2.
- Object 2 never returns done, TIMEOUT_CYCLES=16 → `upd_req[2]` is high for exactly 16 cycles, `timeout_err`=4'b0100, object 3 is serviced next. `clear_err` then returns `timeout_err` to 0.
- Second SOF while object 1 is busy → `overrun`=1. The frame finishes with `frame_count`=1 and no extra frame is serviced.
- `pause`=1 at SOF → no requests and `frame_count` unchanged. Assert reset mid-request → `upd_req`=0 immediately, FSM back in WAIT_SOF_ST.
- Rotation: with `MOVE_SCHED_ROTATE_EN` defined, three consecutive frames start at objects 0, 1, 2. With it undefined, all three frames start at object 0.
